fetch_exec_controller: RTL

//  Multi-cycle sequencer for the simple RISC CPU. Drives instruction fetch from memory, PC update, decode
//  and per-instruction execute steps by emitting load/select strobes to the register-file/ALU datapath.

---
 rtl/fetch_exec_controller_pkg.sv | 107 ++++++++++
 rtl/fetch_exec_controller_ctrl_wait_counter.sv | 33 +++
 rtl/fetch_exec_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_exec_controller_pkg.sv
// Shared definitions for the fetch/execute sequencer: state and instruction-class encodings,
// opcode/op constants, datapath select codes and the decoder used at DEC.
package fetch_exec_controller_pkg;

    typedef enum logic [4:0] {
        S_RST     = 5'd0,
        S_IF      = 5'd1,
        S_UPC     = 5'd2,
        S_DEC     = 5'd3,
        S_WR_IMM  = 5'd4,
        S_GET_A   = 5'd5,
        S_GET_B   = 5'd6,
        S_SHFT    = 5'd7,
        S_ALU     = 5'd8,
        S_CMP     = 5'd9,
        S_WB      = 5'd10,
        S_ADDR    = 5'd11,
        S_LDA     = 5'd12,
        S_MRD     = 5'd13,
        S_GET_RD  = 5'd14,
        S_STC     = 5'd15,
        S_MWR     = 5'd16,
        S_HALT    = 5'd17,
        S_ILLEGAL = 5'd18
    } state_e;

    typedef enum logic [3:0] {
        CL_MOVI    = 4'd0,
        CL_MOVR    = 4'd1,
        CL_ARITH   = 4'd2,
        CL_CMP     = 4'd3,
        CL_MVN     = 4'd4,
        CL_LDR     = 4'd5,
        CL_STR     = 4'd6,
        CL_HALT    = 4'd7,
        CL_ILLEGAL = 4'd8
    } instr_class_e;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef struct packed {
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halt;
        logic       illegal;
    } ctrl_t;

    function automatic instr_class_e decode_class(input logic [2:0] opcode, input logic [1:0] op);
        instr_class_e cls;
        cls = CL_ILLEGAL;
        if (opcode == OPC_HALT) begin
            cls = CL_HALT;
        end else begin
            case ({opcode, op})
                {OPC_MOV, OP_MOVI}: cls = CL_MOVI;
                {OPC_MOV, OP_MOVR}: cls = CL_MOVR;
                {OPC_ALU, OP_ADD}:  cls = CL_ARITH;
                {OPC_ALU, OP_AND}:  cls = CL_ARITH;
                {OPC_ALU, OP_CMP}:  cls = CL_CMP;
                {OPC_ALU, OP_MVN}:  cls = CL_MVN;
                {OPC_LDR, OP_MEM}:  cls = CL_LDR;
                {OPC_STR, OP_MEM}:  cls = CL_STR;
                default:            cls = CL_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/fetch_exec_controller_ctrl_wait_counter.sv
// Memory-phase cycle counter shared by the instruction fetch and load-read phases.
// Counts 0..MEM_LAT and holds at MEM_LAT; o_done marks the final cycle of the phase.
module ctrl_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_done
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT);

    logic [CW-1:0] r_count;
    logic          w_done;

    assign w_done = (r_count == LAST);
    assign o_done = w_done;

    // Saturates at LAST so a stalled phase can never wrap back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !w_done) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/fetch_exec_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the simple RISC CPU. Moore machine: every
// datapath and memory strobe is decoded from the current state and the memory wait counter.
module fetch_exec_controller
    import fetch_exec_controller_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halt,
    output logic       illegal,
    output logic [4:0] dbg_state
);

    state_e       r_state;
    state_e       w_next;
    instr_class_e r_class;
    instr_class_e w_dec_class;
    logic         w_wait_en;
    logic         w_wait_clr;
    logic         w_wait_done;
    ctrl_t        w_ctrl;

    assign w_dec_class = decode_class(opcode, op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // The class is latched at DEC so later branches ignore any change on opcode/op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_class <= CL_ILLEGAL;
        end else if (r_state == S_DEC) begin
            r_class <= w_dec_class;
        end
    end

    assign w_wait_en  = (r_state == S_IF) || (r_state == S_MRD);
    assign w_wait_clr = ((w_next == S_IF) || (w_next == S_MRD)) && (w_next != r_state);

    ctrl_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clear (w_wait_clr),
        .i_en    (w_wait_en),
        .o_done  (w_wait_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_IF;
            S_IF:     if (w_wait_done) w_next = S_UPC;
            S_UPC:    w_next = S_DEC;
            S_DEC: begin
                case (w_dec_class)
                    CL_MOVI:                     w_next = S_WR_IMM;
                    CL_MOVR, CL_MVN:             w_next = S_GET_B;
                    CL_ARITH, CL_CMP,
                    CL_LDR, CL_STR:              w_next = S_GET_A;
                    CL_HALT:                     w_next = S_HALT;
                    default:                     w_next = S_ILLEGAL;
                endcase
            end
            S_WR_IMM: w_next = S_IF;
            S_GET_A:  w_next = ((r_class == CL_LDR) || (r_class == CL_STR)) ? S_ADDR : S_GET_B;
            S_GET_B: begin
                case (r_class)
                    CL_MOVR: w_next = S_SHFT;
                    CL_CMP:  w_next = S_CMP;
                    default: w_next = S_ALU;
                endcase
            end
            S_SHFT:   w_next = S_WB;
            S_ALU:    w_next = S_WB;
            S_CMP:    w_next = S_IF;
            S_WB:     w_next = S_IF;
            S_ADDR:   w_next = S_LDA;
            S_LDA:    w_next = (r_class == CL_LDR) ? S_MRD : S_GET_RD;
            S_MRD:    if (w_wait_done) w_next = S_IF;
            S_GET_RD: w_next = S_STC;
            S_STC:    w_next = S_MWR;
            S_MWR:    w_next = S_IF;
            S_HALT:   w_next = S_HALT;
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:  w_next = S_RST;
        endcase
    end

    // Outputs are forced idle while reset is held low, including the RST state itself.
    always_comb begin
        w_ctrl         = '0;
        w_ctrl.nsel    = NSEL_NONE;
        w_ctrl.mem_cmd = MEM_NONE;
        if (reset) begin
            case (r_state)
                S_RST: begin
                    w_ctrl.reset_pc = 1'b1;
                    w_ctrl.load_pc  = 1'b1;
                end
                S_IF: begin
                    w_ctrl.addr_sel = 1'b1;
                    w_ctrl.mem_cmd  = MEM_READ;
                    w_ctrl.load_ir  = w_wait_done;
                end
                S_UPC:    w_ctrl.load_pc = 1'b1;
                S_WR_IMM: begin
                    w_ctrl.nsel  = NSEL_RN;
                    w_ctrl.vsel  = VSEL_IMM;
                    w_ctrl.write = 1'b1;
                end
                S_GET_A: begin
                    w_ctrl.nsel  = NSEL_RN;
                    w_ctrl.loada = 1'b1;
                end
                S_GET_B: begin
                    w_ctrl.nsel  = NSEL_RM;
                    w_ctrl.loadb = 1'b1;
                end
                S_SHFT: begin
                    w_ctrl.asel  = 1'b1;
                    w_ctrl.loadc = 1'b1;
                end
                S_ALU:    w_ctrl.loadc = 1'b1;
                S_CMP:    w_ctrl.loads = 1'b1;
                S_WB: begin
                    w_ctrl.nsel  = NSEL_RD;
                    w_ctrl.vsel  = VSEL_C;
                    w_ctrl.write = 1'b1;
                end
                S_ADDR: begin
                    w_ctrl.bsel  = 1'b1;
                    w_ctrl.loadc = 1'b1;
                end
                S_LDA:    w_ctrl.load_addr = 1'b1;
                S_MRD: begin
                    w_ctrl.mem_cmd = MEM_READ;
                    if (w_wait_done) begin
                        w_ctrl.nsel  = NSEL_RD;
                        w_ctrl.vsel  = VSEL_MDATA;
                        w_ctrl.write = 1'b1;
                    end
                end
                S_GET_RD: begin
                    w_ctrl.nsel  = NSEL_RD;
                    w_ctrl.loadb = 1'b1;
                end
                S_STC: begin
                    w_ctrl.asel  = 1'b1;
                    w_ctrl.loadc = 1'b1;
                end
                S_MWR:    w_ctrl.mem_cmd = MEM_WRITE;
                S_HALT:   w_ctrl.halt = 1'b1;
                S_ILLEGAL: begin
                    w_ctrl.halt    = 1'b1;
                    w_ctrl.illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign nsel      = w_ctrl.nsel;
    assign loada     = w_ctrl.loada;
    assign loadb     = w_ctrl.loadb;
    assign loadc     = w_ctrl.loadc;
    assign loads     = w_ctrl.loads;
    assign asel      = w_ctrl.asel;
    assign bsel      = w_ctrl.bsel;
    assign vsel      = w_ctrl.vsel;
    assign write     = w_ctrl.write;
    assign load_ir   = w_ctrl.load_ir;
    assign load_pc   = w_ctrl.load_pc;
    assign reset_pc  = w_ctrl.reset_pc;
    assign addr_sel  = w_ctrl.addr_sel;
    assign load_addr = w_ctrl.load_addr;
    assign mem_cmd   = w_ctrl.mem_cmd;
    assign halt      = w_ctrl.halt;
    assign illegal   = w_ctrl.illegal;
    assign dbg_state = r_state;

endmodule
